mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequencing controller for the MAR/MDR/MEM datapath. It accepts single-word read or write requests from a requester (CPU control unit or test master) and drives the bus driver, MAR load, MDR enables and MEM `R_W`/`EN` strobes in the correct order. It waits on the memory's `MFC` handshake and returns read data or completion status. One access is in flight at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles waited on any single `MFC` edge. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  request valid; accepted when `req && ready` on a rising edge.
- `we`  in  1  1 = write, 0 = read; sampled at accept.
- `addr`  in  16  word address; sampled at accept.
- `wdata`  in  16  write data; sampled at accept.
- `ready`  out  1  controller idle, can accept a request.
- `done`  out  1  one-cycle pulse at access completion.
- `err`  out  1  valid with `done`; 1 = access timed out.
- `rdata`  out  16  read result; updated only by reads, held until the next read.
- `busOut`  out  16  value presented to the bus driver.
- `loadBus`  out  1  bus driver enable.
- `marLoad`  out  1  MAR load from bus.
- `mdrWriteEn`  out  1  MDR load from bus (write path).
- `mdrReadEn`  out  1  MDR load from MEM read data.
- `mdrOutEn`  out  1  MDR drives bus.
- `memRW`  out  1  1 = read, 0 = write.
- `memEn`  out  1  MEM enable.
- `MFC`  in  1  memory function complete.
- `bus`  in  16  shared bus value, observed when MDR drives it.

## Operation
- FSM states: IDLE, LD_MAR, LD_MDR, MEM_ACC, MDR_CAP, MDR_OUT, RELEASE, DONE.
- IDLE: `ready`=1. On accept, latch `we`, `addr` and `wdata`, then go to LD_MAR.
- LD_MAR: `loadBus`=1, `busOut`=addr, `marLoad`=1. Next state is LD_MDR if `we`, else MEM_ACC.
- LD_MDR: `loadBus`=1, `busOut`=wdata, `mdrWriteEn`=1. Next state is MEM_ACC.
- MEM_ACC: `memEn`=1, `memRW`=~we. Remain here until `MFC`=1 is sampled. Then go to MDR_CAP for a read or RELEASE for a write.
- MDR_CAP: `memEn`=1, `memRW`=1, `mdrReadEn`=1. Next state is MDR_OUT.
- MDR_OUT: `mdrOutEn`=1. At the end of this cycle, `rdata` <= `bus`. Next state is RELEASE.
- RELEASE: `memEn`=0. Remain here until `MFC`=0 is sampled, then go to DONE. This blocks back-to-back accesses on a stale `MFC`.
- DONE: `done`=1, `err` reflects the access result. Next state is IDLE.
- All datapath strobes are 0 in any state not listed as driving them. `loadBus` and `mdrOutEn` are never 1 in the same cycle.
- `busOut` is 0 whenever `loadBus`=0.
- `req` asserted outside IDLE is ignored; the request is neither queued nor lost-flagged.

## Timing
- All outputs are registered or decoded from the state register.
- Reset values: `ready`=0 while `reset`=1 and 1 after the first idle cycle; `done`=0, `err`=0, `rdata`=0, and all strobes and `busOut`=0.
- Minimum latency, counted from the accept edge to the cycle `done` is high, with `MFC` responding immediately:
  - write: 5 cycles (LD_MAR, LD_MDR, MEM_ACC, RELEASE, DONE).
  - read: 6 cycles (LD_MAR, MEM_ACC, MDR_CAP, MDR_OUT, RELEASE, DONE).
- Each extra cycle of `MFC` low in MEM_ACC, or `MFC` high in RELEASE, adds one cycle of latency.
- `ready` returns in the cycle after DONE. The next accept is possible on that edge.
- Reset mid-access: on the next edge, return to IDLE and force all strobes to 0. The in-flight access is abandoned; no `done` pulse is issued and `rdata` is cleared.
- `MFC` already high on entry to MEM_ACC: MEM_ACC lasts exactly 1 cycle.

## Configuration
- Macro: `MEM_ACCESS_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to MEM_ACC and RELEASE and increments each cycle spent in those states.
  - When it reaches `TIMEOUT_CYCLES`, jump to DONE with `err`=1 and `memEn`=0. On a timed-out read, `rdata` is not updated.
- Undefined:
  - No counter.
  - The controller waits on `MFC` indefinitely.
  - `err` is tied to 0.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - state encodings, as localparams with 3-bit width;
  - the `memRW` encodings `MEM_READ`=1 and `MEM_WRITE`=0;
  - the 16-bit data/address width constant.
- One sub-module, `mem_timeout_ctr`: a clear/enable/terminal-count counter. It is instantiated only under `MEM_ACCESS_TIMEOUT_EN`.

## Test plan
- Write 15 to address 7, with `MFC` rising 2 cycles after `memEn`:
  - required strobe order: `marLoad` with `busOut`=7, then `mdrWriteEn` with `busOut`=15, then `memEn`=1/`memRW`=0;
  - `done`=1 with `err`=0 at 7 cycles after accept;
  - MEM[7]=15.
- Read address 7 after that write: `rdata`=15 at `done`, and `memRW`=1 throughout MEM_ACC and MDR_CAP.
- Back-to-back read requests with `MFC` held high 3 cycles after `memEn` drops: the second accept waits until `MFC`=0 and `done` has pulsed; no overlap of `memEn`.
- Assert `reset` during MEM_ACC of a write: next cycle all strobes are 0, `ready`=1 after release, and there is no `done` pulse.
- With `MEM_ACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, and `MFC` stuck at 0: `done`=1, `err`=1, and `memEn` drops after 8 MEM_ACC cycles. Without the macro, the controller stays in MEM_ACC with `memEn`=1.
- `req` pulsed during an active read: ignored, and exactly one `done` is produced.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MAR/MDR/MEM access controller: data/address
// width, FSM state encodings and the memory read/write strobe encoding.
package mem_ctrl_pkg;

    localparam int DATA_W = 16;

    // State encodings (3 bits, one value per FSM state).
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_MAR  = 3'd1;
    localparam logic [2:0] S_LD_MDR  = 3'd2;
    localparam logic [2:0] S_MEM_ACC = 3'd3;
    localparam logic [2:0] S_MDR_CAP = 3'd4;
    localparam logic [2:0] S_MDR_OUT = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        LD_MAR  = S_LD_MAR,
        LD_MDR  = S_LD_MDR,
        MEM_ACC = S_MEM_ACC,
        MDR_CAP = S_MDR_CAP,
        MDR_OUT = S_MDR_OUT,
        RELEASE = S_RELEASE,
        DONE    = S_DONE
    } state_t;

    // memRW encodings.
    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable/terminal-count counter used to bound the wait on each MFC
// edge. tc is high while the count sits at TERMINAL-1, so a wait that starts
// with a clear lasts exactly TERMINAL cycles before tc is seen.
module mem_timeout_ctr #(
    parameter int TERMINAL = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] count;

    assign tc = (count == LAST);

    // Count cycles spent waiting; saturate at the terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-word access sequencer for the MAR/MDR/MEM datapath.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (bounded wait on MFC,
// reported through err). Without it the controller waits on MFC forever.
//
// Request handshake: a request transfers on a rising edge where req and
// ready are both 1; we/addr/wdata are captured on that edge only. ready is
// low for the whole access and req is ignored (not queued) while it is low.
// Completion is a one-cycle done pulse with err valid in the same cycle.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] busOut,
    output logic              loadBus,
    output logic              marLoad,
    output logic              mdrWriteEn,
    output logic              mdrReadEn,
    output logic              mdrOutEn,
    output logic              memRW,
    output logic              memEn,
    input  logic              MFC,
    input  logic [DATA_W-1:0] bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state;
    state_t            next_state;
    logic              ready_q;
    logic              accept;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              timeout;
    logic              timeout_jump;

    assign accept = req && ready_q && (state == IDLE);
    assign ready  = ready_q;
    assign rdata  = rdata_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic ctr_tc;
    logic ctr_en;
    logic ctr_clear;

    // The counter restarts on every state change, so entering MEM_ACC or
    // RELEASE always begins a fresh wait.
    assign ctr_en    = (state == MEM_ACC) || (state == RELEASE);
    assign ctr_clear = (next_state != state);
    assign timeout   = ctr_en && ctr_tc;

    mem_timeout_ctr #(
        .TERMINAL(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clear (ctr_clear),
        .enable(ctr_en),
        .tc    (ctr_tc)
    );
`else
    assign timeout = 1'b0;
`endif

    // State register and registered ready (low during reset and the first idle cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE);
        end
    end

    // Capture the request fields on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Read result comes off the bus at the end of MDR_OUT; held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == MDR_OUT) begin
            rdata_q <= bus;
        end
    end

    // Access status: cleared at accept, set when a wait gives up.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_jump) begin
            err_q <= 1'b1;
        end
    end

    // Next-state logic; MFC wins over a timeout landing in the same cycle.
    always_comb begin
        next_state   = state;
        timeout_jump = 1'b0;
        case (state)
            IDLE:    if (accept) next_state = LD_MAR;
            LD_MAR:  next_state = we_q ? LD_MDR : MEM_ACC;
            LD_MDR:  next_state = MEM_ACC;
            MEM_ACC: begin
                if (MFC) begin
                    next_state = we_q ? RELEASE : MDR_CAP;
                end else if (timeout) begin
                    next_state   = DONE;
                    timeout_jump = 1'b1;
                end
            end
            MDR_CAP: next_state = MDR_OUT;
            MDR_OUT: next_state = RELEASE;
            RELEASE: begin
                if (!MFC) begin
                    next_state = DONE;
                end else if (timeout) begin
                    next_state   = DONE;
                    timeout_jump = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath strobes decoded from the state register; everything idles at 0.
    always_comb begin
        busOut     = '0;
        loadBus    = 1'b0;
        marLoad    = 1'b0;
        mdrWriteEn = 1'b0;
        mdrReadEn  = 1'b0;
        mdrOutEn   = 1'b0;
        memRW      = MEM_WRITE;
        memEn      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            LD_MAR: begin
                loadBus = 1'b1;
                busOut  = addr_q;
                marLoad = 1'b1;
            end
            LD_MDR: begin
                loadBus    = 1'b1;
                busOut     = wdata_q;
                mdrWriteEn = 1'b1;
            end
            MEM_ACC: begin
                memEn = 1'b1;
                memRW = we_q ? MEM_WRITE : MEM_READ;
            end
            MDR_CAP: begin
                memEn     = 1'b1;
                memRW     = MEM_READ;
                mdrReadEn = 1'b1;
            end
            MDR_OUT: mdrOutEn = 1'b1;
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule
